// File: rtl/iir_2nd_inverse_serial_pkg.sv
// iir_2nd_inverse_serial_pkg: FSM encoding, coefficient quantisation and shift-saturate helpers
package iir_2nd_inverse_serial_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_MAC   = 2'd1;
  localparam state_t S_SCALE = 2'd2;
  localparam state_t S_OUT   = 2'd3;
  // round-half-away quantisation of a real coefficient to w-bit Q(w-fw).fw, clamped
  function automatic logic signed [63:0] coef_q(input real c, input int w, input int fw);
    longint r, hi;
    r = longint'(c * real'(longint'(1) << fw));
    hi = (longint'(1) << (w - 1)) - 1;
    return (r > hi) ? hi : (r < -hi - 1) ? -hi - 1 : r;
  endfunction
  // arithmetic >>> fw (floor) then clamp to the signed w-bit range
  function automatic logic signed [63:0] sat_w(input logic signed [127:0] x, input int w, input int fw);
    logic signed [127:0] s, hi, lo;
    s = x >>> fw;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    return (s > hi) ? hi[63:0] : (s < lo) ? lo[63:0] : s[63:0];
  endfunction
endpackage

// File: rtl/iir_2nd_inverse_serial_if.sv
// iir_2nd_inverse_serial_if: valid/ready sample streams into and out of the inverse biquad
interface iir_2nd_inverse_serial_if #(parameter int w = 32) ();
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [w-1:0] in_data, out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/iir_2nd_inverse_serial_mul_sat.sv
// iir_2nd_inverse_serial_mul_sat: shared w x w signed multiplier with full product and Q-scaled saturated result
module iir_2nd_inverse_serial_mul_sat
  import iir_2nd_inverse_serial_pkg::*;
#(
  parameter int w  = 32,
  parameter int FW = 16
) (
  input  logic signed [w-1:0]   a_i,
  input  logic signed [w-1:0]   b_i,
  output logic signed [2*w-1:0] prod_o,
  output logic signed [w-1:0]   sat_o
);
  assign prod_o = (2*w)'(a_i) * (2*w)'(b_i);
  assign sat_o = w'(sat_w({{(128-2*w){prod_o[2*w-1]}}, prod_o}, w, FW));
endmodule

// File: rtl/iir_2nd_inverse_serial.sv
// iir_2nd_inverse_serial: inverse 2nd-order IIR, x = INV_N0*(y + D1*y1 + D2*y2 - N1*x1 - N2*x2),
// one shared multiplier stepped over IDLE, MAC x4, SCALE, OUT.
module iir_2nd_inverse_serial
  import iir_2nd_inverse_serial_pkg::*;
#(
  parameter int  w  = 32,
  parameter int  FW = 16,
  parameter real N0 = 1.0,
  parameter real N1 = 0.0,
  parameter real N2 = 0.0,
  parameter real D1 = 0.0,
  parameter real D2 = 0.0
) (
  input logic clk,
  input logic rst_n,
  iir_2nd_inverse_serial_if.slave bus
);
  localparam real INV_N0 = 1.0 / N0;
  localparam int  AW = 2 * w + 3;
  localparam logic signed [w-1:0] C_D1  = w'(coef_q(D1, w, FW));
  localparam logic signed [w-1:0] C_D2  = w'(coef_q(D2, w, FW));
  localparam logic signed [w-1:0] C_N1  = w'(coef_q(-N1, w, FW));
  localparam logic signed [w-1:0] C_N2  = w'(coef_q(-N2, w, FW));
  localparam logic signed [w-1:0] C_INV = w'(coef_q(INV_N0, w, FW));

  state_t state_q, state_d;
  logic [1:0] k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [w-1:0] y_q, y_d, y1_q, y1_d, y2_q, y2_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [w-1:0] out_q, out_d, t, op_a, op_b, scaled;
  logic signed [2*w-1:0] prod;
  logic out_valid_q, out_valid_d;

  assign t = w'(sat_w({{(128-AW){acc_q[AW-1]}}, acc_q}, w, FW));
  // MAC walks the four history taps; every other state feeds the final 1/N0 scaling
  assign op_a = (state_q == S_MAC) ? ((k_q == 2'd0) ? C_D1 : (k_q == 2'd1) ? C_D2 :
                                      (k_q == 2'd2) ? C_N1 : C_N2) : C_INV;
  assign op_b = (state_q == S_MAC) ? ((k_q == 2'd0) ? y1_q : (k_q == 2'd1) ? y2_q :
                                      (k_q == 2'd2) ? x1_q : x2_q) : t;

  iir_2nd_inverse_serial_mul_sat #(.w(w), .FW(FW)) u_mul (
    .a_i   (op_a),
    .b_i   (op_b),
    .prod_o(prod),
    .sat_o (scaled)
  );

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;

  always_comb begin
    state_d = state_q;
    k_d = k_q;
    acc_d = acc_q;
    y_d = y_q;
    y1_d = y1_q;
    y2_d = y2_q;
    x1_d = x1_q;
    x2_d = x2_q;
    out_d = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        y_d = bus.in_data;
        acc_d = {{(AW-w){bus.in_data[w-1]}}, bus.in_data} <<< FW;
        k_d = 2'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + {{(AW-2*w){prod[2*w-1]}}, prod};
        k_d = k_q + 2'd1;
        state_d = (k_q == 2'd3) ? S_SCALE : S_MAC;
      end
      S_SCALE: begin
        out_d = scaled;
        out_valid_d = 1'b1;
        state_d = S_OUT;
      end
      // history advances only once the sample is delivered
      default: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        y2_d = y1_q;
        y1_d = y_q;
        x2_d = x1_q;
        x1_d = out_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q <= '0;
      acc_q <= '0;
      y_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      acc_q <= acc_d;
      y_q <= y_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_iir_2nd_inverse_serial.sv
// tb_iir_2nd_inverse_serial: four parameterisations of the inverse biquad checked against a
// fixed-point model of the recurrence x = (y + D1*y1 + D2*y2 - N1*x1 - N2*x2) / N0.
module tb_iir_2nd_inverse_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic iv[4], ordy[4], irdy[4], ov[4];
  logic signed [31:0] idat[4], odat[4];
  int n_chk = 0;
  int n_fail = 0;

  iir_2nd_inverse_serial_if #(.w(32)) bus[4] ();
  for (genvar g = 0; g < 4; g++) begin : g_bind
    assign bus[g].in_valid  = iv[g];
    assign bus[g].in_data   = idat[g];
    assign bus[g].out_ready = ordy[g];
    assign irdy[g] = bus[g].in_ready;
    assign ov[g]   = bus[g].out_valid;
    assign odat[g] = bus[g].out_data;
  end

  iir_2nd_inverse_serial u_id (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
  iir_2nd_inverse_serial #(.N0(1.0), .N1(-2.0), .N2(1.0), .D1(-1.5), .D2(0.5625))
    u_rt (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
  iir_2nd_inverse_serial #(.D1(1.9)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus[2]));
  iir_2nd_inverse_serial #(.N1(-0.5)) u_rst (.clk(clk), .rst_n(rst_n), .bus(bus[3]));

  // coefficients as round(C * 2^16) for each instance; 1/N0 is 1.0 everywhere
  longint qd1[4] = '{0, -98304, 124518, 0};
  longint qd2[4] = '{0, 36864, 0, 0};
  longint qn1[4] = '{0, -131072, 0, -32768};
  longint qn2[4] = '{0, 65536, 0, 0};
  logic signed [31:0] hy1[4], hy2[4], hx1[4], hx2[4];

  function automatic logic signed [31:0] sat32(input logic signed [127:0] v);
    return (v > 128'sd2147483647) ? 32'sh7FFFFFFF : (v < -128'sd2147483648) ? 32'sh80000000 : v[31:0];
  endfunction

  task automatic model(input int d, input logic signed [31:0] y, output logic signed [31:0] x);
    logic signed [127:0] ys, y1, y2, x1, x2, a, t;
    ys = y; y1 = hy1[d]; y2 = hy2[d]; x1 = hx1[d]; x2 = hx2[d];
    a = ys * 128'sd65536 + qd1[d] * y1 + qd2[d] * y2 - qn1[d] * x1 - qn2[d] * x2;
    t = sat32(a >>> 16);
    x = sat32((t * 128'sd65536) >>> 16);
    hy2[d] = hy1[d]; hy1[d] = y; hx2[d] = hx1[d]; hx1[d] = x;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      hy1[d] = 0; hy2[d] = 0; hx1[d] = 0; hx2[d] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_clear();
  endtask

  task automatic send(input int d, input logic signed [31:0] v);
    int n = 0;
    @(negedge clk);
    while (!irdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    iv[d] = 1'b1;
    idat[d] = v;
    @(posedge clk);
    #1 iv[d] = 1'b0;
  endtask

  // lat counts rising edges from the accept edge (inclusive) until out_valid is seen; -1 on timeout
  task automatic recv(input int d, input int stall, output logic signed [31:0] v, output int lat);
    lat = 1;
    while (!ov[d] && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!ov[d]) begin
      v = 'x;
      lat = -1;
      return;
    end
    v = odat[d];
    ordy[d] = 1'b0;
    repeat (stall) @(posedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++; if (irdy[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, irdy[d]); end
      n_chk++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, ov[d]); end
      n_chk++; if (odat[d] !== 32'sd0) begin n_fail++; $display("FAIL reset_out[%0d]: got %h expected 0", d, odat[d]); end
    end
    @(negedge clk) rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_identity();
    logic signed [31:0] got, e;
    int lat;
    send(0, 32'sh00010000);
    recv(0, 0, got, lat);
    model(0, 32'sh00010000, e);
    n_chk++; if (got !== 32'sh00010000) begin n_fail++; $display("FAIL identity_out: got %h expected 00010000", got); end
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL identity_latency: got %0d expected 6", lat); end
  endtask

  task automatic test_random();
    logic signed [31:0] v, got, e;
    int lat;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++) begin
        v = $urandom;
        if (i % 2 == 1) v = v >>> 10;
        send(d, v);
        recv(d, $urandom_range(0, 3), got, lat);
        model(d, v, e);
        n_chk++; if (got !== e) begin n_fail++; $display("FAIL random[%0d.%0d] in %h: got %h expected %h", d, i, v, got, e); end
      end
    end
  endtask

  task automatic test_round_trip();
    logic signed [127:0] fx1, fx2, fy1, fy2, xi, yf;
    logic signed [31:0] y32, got, e;
    longint dlt;
    int lat;
    do_reset();
    fx1 = 0; fx2 = 0; fy1 = 0; fy2 = 0;
    for (int n = 0; n < 64; n++) begin
      xi = (n == 0) ? 128'sd65536 : 128'sd0;
      yf = (128'sd65536 * xi - 128'sd131072 * fx1 + 128'sd65536 * fx2
            + 128'sd98304 * fy1 - 128'sd36864 * fy2) >>> 16;
      fx2 = fx1; fx1 = xi; fy2 = fy1; fy1 = yf;
      y32 = yf[31:0];
      send(1, y32);
      recv(1, 0, got, lat);
      model(1, y32, e);
      n_chk++; if (got !== e) begin n_fail++; $display("FAIL round_trip[%0d]: got %h expected %h", n, got, e); end
      // zeros at z=1 double-integrate the forward filter's truncation residue, which first appears at n=9
      if (n < 10) begin
        dlt = longint'(got) - longint'(xi[31:0]);
        n_chk++; if (dlt > 2 || dlt < -2) begin n_fail++; $display("FAIL round_trip_impulse[%0d]: got %h expected %h +/-2", n, got, xi[31:0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] v, e;
    int n = 0;
    v = $urandom;
    model(0, v, e);
    send(0, v);
    ordy[0] = 1'b0;
    while (!ov[0] && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_chk++; if (ov[0] !== 1'b1 || odat[0] !== e) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid %b out %h expected 1 %h", i, ov[0], odat[0], e); end
      n_chk++; if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, irdy[0]); end
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready %b out_valid %b expected 1 0", irdy[0], ov[0]); end
  endtask

  task automatic test_saturation();
    logic signed [31:0] got, e;
    int lat;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(2, 32'sh7FFFFFFF);
      recv(2, 0, got, lat);
      model(2, 32'sh7FFFFFFF, e);
      n_chk++; if (got !== 32'sh7FFFFFFF || got !== e) begin n_fail++; $display("FAIL sat_pos[%0d]: got %h expected 7fffffff", i, got); end
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(2, 32'sh80000000);
      recv(2, 0, got, lat);
      model(2, 32'sh80000000, e);
      n_chk++; if (got !== 32'sh80000000 || got !== e) begin n_fail++; $display("FAIL sat_neg[%0d]: got %h expected 80000000", i, got); end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [31:0] c, got, e;
    int lat;
    do_reset();
    send(3, 32'sh00020000);
    recv(3, 0, got, lat);
    model(3, 32'sh00020000, e);
    send(3, 32'sh00050000);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++; if (ov[3] !== 1'b0 || irdy[3] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_state: got valid %b in_ready %b expected 0 1", ov[3], irdy[3]); end
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    c = $urandom_range(1, 32'h00FFFFFF);
    send(3, c);
    recv(3, 0, got, lat);
    model(3, c, e);
    n_chk++; if (got !== c) begin n_fail++; $display("FAIL reset_mid_history: got %h expected %h", got, c); end
    send(3, 32'sh00010000);
    recv(3, 0, got, lat);
    model(3, 32'sh00010000, e);
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL reset_mid_next: got %h expected %h", got, e); end
  endtask

  task automatic test_busy_input();
    logic signed [31:0] a, b, got, e;
    int lat;
    a = 32'sh00123456;
    b = 32'sh00654321;
    send(0, a);
    @(negedge clk);
    n_chk++; if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready: got %b expected 0", irdy[0]); end
    iv[0] = 1'b1;
    idat[0] = b;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    recv(0, 0, got, lat);
    model(0, a, e);
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL busy_ignored: got %h expected %h", got, e); end
    send(0, b);
    recv(0, 0, got, lat);
    model(0, b, e);
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL busy_next: got %h expected %h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] v, e;
    logic signed [31:0] exp_q[$];
    int k = 0, got_n = 0, last = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (ov[0]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'sh0;
        n_chk++; if (odat[0] !== e) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h expected %h", got_n, odat[0], e); end
        got_n++;
      end
      if (irdy[0]) begin
        if (k < 5) begin
          v = $urandom;
          idat[0] = v;
          iv[0] = 1'b1;
          model(0, v, e);
          exp_q.push_back(e);
          if (k > 0) begin
            n_chk++; if (cyc - last !== 7) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 7", k, cyc - last); end
          end
          last = cyc;
          k++;
        end else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    n_chk++; if (got_n !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", got_n); end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      idat[d] = 32'sd0;
    end
    test_reset();
    test_identity();
    test_random();
    test_round_trip();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_busy_input();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
